// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - four-channel DMA request arbiter and bus-hold sequencer
module dma_channel_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              rotatingPriority,
    input  logic              dreqSenseActiveLow,
    input  logic              dackSenseActiveHigh,
    input  logic              controllerDisable,
    input  logic              transferDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [1:0]        grantChannel
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GRANTED = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        ptr;
    logic [1:0]        ptr_next;
    logic [1:0]        gch_next;
    logic              hrq_next;
    logic              gv_next;
    logic [NUM_CH-1:0] dack_next;
    logic [NUM_CH-1:0] dack_idle;
    logic [NUM_CH-1:0] eff;
    logic              found;
    logic [1:0]        winner;
    logic [1:0]        idx;

    // Software requests bypass both the mask and the DREQ sense inversion.
    assign eff       = ((DREQ ^ {NUM_CH{dreqSenseActiveLow}}) & ~maskReg) | requestReg;
    assign dack_idle = {NUM_CH{~dackSenseActiveHigh}};

    // ptr names the lowest-priority channel, so the rotating search starts one past it.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = rotatingPriority ? (ptr + 2'(k + 1)) : 2'(k);
            if (!found && eff[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gch_next   = grantChannel;
        case (state)
            IDLE: begin
                if (|eff && !controllerDisable) begin
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (HLDA) begin
                    if (found) begin
                        state_next = GRANTED;
                        gch_next   = winner;
                    end else begin
                        state_next = RELEASE;
                    end
                end
            end
            GRANTED: begin
                // A rescinded HLDA aborts the grant and outranks a coincident transferDone.
                if (!HLDA) begin
                    state_next = IDLE;
                end else if (transferDone) begin
                    state_next = RELEASE;
                    ptr_next   = grantChannel;
                end
            end
            RELEASE: begin
                if (!HLDA) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        hrq_next  = (state_next == REQUEST) || (state_next == GRANTED);
        gv_next   = (state_next == GRANTED);
        dack_next = dack_idle;
        if (gv_next) begin
            dack_next = dack_idle ^ (NUM_CH'(1) << gch_next);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            ptr          <= 2'd3;
            HRQ          <= 1'b0;
            DACK         <= dack_idle;
            grantValid   <= 1'b0;
            grantChannel <= 2'd0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            HRQ          <= hrq_next;
            DACK         <= dack_next;
            grantValid   <= gv_next;
            grantChannel <= gch_next;
        end
    end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - directed vector bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

    logic       CLK;
    logic       RESET;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       rotatingPriority;
    logic       dreqSenseActiveLow;
    logic       dackSenseActiveHigh;
    logic       controllerDisable;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;

    int checks   = 0;
    int failures = 0;

    dma_channel_arbiter #(.NUM_CH(4)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .DREQ                (DREQ),
        .HLDA                (HLDA),
        .maskReg             (maskReg),
        .requestReg          (requestReg),
        .rotatingPriority    (rotatingPriority),
        .dreqSenseActiveLow  (dreqSenseActiveLow),
        .dackSenseActiveHigh (dackSenseActiveHigh),
        .controllerDisable   (controllerDisable),
        .transferDone        (transferDone),
        .HRQ                 (HRQ),
        .DACK                (DACK),
        .grantValid          (grantValid),
        .grantChannel        (grantChannel)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] dreq;
        logic       hlda;
        logic [3:0] mask;
        logic [3:0] req;
        logic       rot;
        logic       dlo;
        logic       dhi;
        logic       dis;
        logic       done;
        logic       hrq;
        logic [3:0] dack;
        logic       gv;
        logic [1:0] gch;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [3:0] dreq, logic hlda, logic [3:0] mask,
                                logic [3:0] req, logic rot, logic dlo, logic dhi, logic dis,
                                logic done, logic hrq, logic [3:0] dack, logic gv, logic [1:0] gch);
        vec_t v;
        v.rst = rst;   v.dreq = dreq; v.hlda = hlda; v.mask = mask; v.req = req;
        v.rot = rot;   v.dlo = dlo;   v.dhi = dhi;   v.dis = dis;   v.done = done;
        v.hrq = hrq;   v.dack = dack; v.gv = gv;     v.gch = gch;
        return v;
    endfunction

    task automatic chk_out(input string name, input logic hrq, input logic [3:0] dack,
                           input logic gv, input logic [1:0] gch);
        checks++;
        if (HRQ !== hrq) begin
            failures++;
            $display("FAIL %s HRQ actual=%0b required=%0b", name, HRQ, hrq);
        end
        checks++;
        if (DACK !== dack) begin
            failures++;
            $display("FAIL %s DACK actual=%04b required=%04b", name, DACK, dack);
        end
        checks++;
        if (grantValid !== gv) begin
            failures++;
            $display("FAIL %s grantValid actual=%0b required=%0b", name, grantValid, gv);
        end
        checks++;
        if (grantChannel !== gch) begin
            failures++;
            $display("FAIL %s grantChannel actual=%0d required=%0d", name, grantChannel, gch);
        end
    endtask

    task automatic chk_ptr(input string name, input logic [1:0] exp);
        checks++;
        if (dut.ptr !== exp) begin
            failures++;
            $display("FAIL %s ptr actual=%0d required=%0d", name, dut.ptr, exp);
        end
    endtask

    task automatic step_chk(input string name, input logic hrq, input logic [3:0] dack,
                            input logic gv, input logic [1:0] gch);
        @(posedge CLK);
        #1;
        chk_out(name, hrq, dack, gv, gch);
    endtask

    initial begin
        logic [3:0] exp_dack;
        int         exp_ch;
        RESET = 1'b1; DREQ = 4'h0; HLDA = 1'b0; maskReg = 4'h0; requestReg = 4'h0;
        rotatingPriority = 1'b0; dreqSenseActiveLow = 1'b0; dackSenseActiveHigh = 1'b0;
        controllerDisable = 1'b0; transferDone = 1'b0;

        //                rst dreq    hlda mask    req     rot dlo dhi dis done  hrq dack    gv gch
        vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0)); // reset
        vecs.push_back(mk(0, 4'b1010, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b1111, 0, 0)); // HRQ up
        vecs.push_back(mk(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b1101, 1, 1)); // fixed ch1
        vecs.push_back(mk(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b1101, 1, 1));
        vecs.push_back(mk(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1,   0, 4'b1111, 0, 1)); // done
        vecs.push_back(mk(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 1)); // release holds
        vecs.push_back(mk(0, 4'b1010, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 1)); // to idle
        vecs.push_back(mk(0, 4'b1010, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b1111, 0, 1));
        vecs.push_back(mk(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b1101, 1, 1)); // ch1 again
        vecs.push_back(mk(0, 4'b1010, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1,   0, 4'b1111, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 1));
        vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 1)); // masked
        vecs.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0100, 0, 0, 0, 0, 0,   1, 4'b1111, 0, 1)); // sw req
        vecs.push_back(mk(0, 4'b0001, 1, 4'b0001, 4'b0100, 0, 0, 0, 0, 0,   1, 4'b1011, 1, 2)); // ch2
        vecs.push_back(mk(0, 4'b0001, 1, 4'b0001, 4'b0100, 0, 0, 0, 0, 1,   0, 4'b1111, 0, 2));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 2));
        vecs.push_back(mk(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b1111, 0, 2)); // request
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1,   1, 4'b1111, 0, 2)); // withdrawn, stray done
        vecs.push_back(mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 2)); // to release
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 2));
        vecs.push_back(mk(0, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 0,   0, 4'b1111, 0, 2)); // disabled
        vecs.push_back(mk(0, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b1111, 0, 2));
        vecs.push_back(mk(0, 4'b1000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   1, 4'b0111, 1, 3)); // ch3
        vecs.push_back(mk(0, 4'b1000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 0,   1, 4'b0111, 1, 3)); // disable no abort
        vecs.push_back(mk(0, 4'b1000, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 1,   0, 4'b1111, 0, 3)); // abort wins
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 3));
        vecs.push_back(mk(0, 4'b1110, 0, 4'b0000, 4'b0000, 0, 1, 1, 0, 0,   1, 4'b0000, 0, 3)); // active-low dreq
        vecs.push_back(mk(0, 4'b1110, 1, 4'b0000, 4'b0000, 0, 1, 1, 0, 0,   1, 4'b0001, 1, 0)); // ch0 high dack
        vecs.push_back(mk(0, 4'b1110, 1, 4'b0000, 4'b0000, 0, 1, 1, 0, 1,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 4'b0000, 0, 1, 1, 0, 0,   0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b1111, 0, 0));

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            RESET = vecs[i].rst; DREQ = vecs[i].dreq; HLDA = vecs[i].hlda;
            maskReg = vecs[i].mask; requestReg = vecs[i].req; rotatingPriority = vecs[i].rot;
            dreqSenseActiveLow = vecs[i].dlo; dackSenseActiveHigh = vecs[i].dhi;
            controllerDisable = vecs[i].dis; transferDone = vecs[i].done;
            step_chk($sformatf("vec%0d", i), vecs[i].hrq, vecs[i].dack, vecs[i].gv, vecs[i].gch);
        end

        // Rotating priority with every channel requesting.
        RESET = 1'b1; DREQ = 4'h0; HLDA = 1'b0; rotatingPriority = 1'b1;
        maskReg = 4'h0; requestReg = 4'h0; controllerDisable = 1'b0; transferDone = 1'b0;
        dreqSenseActiveLow = 1'b0; dackSenseActiveHigh = 1'b0;
        step_chk("rot_reset", 1'b0, 4'b1111, 1'b0, 2'd0);
        chk_ptr("rot_reset_ptr", 2'd3);
        RESET = 1'b0; DREQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_ch   = i % 4;
            exp_dack = 4'b1111 ^ (4'b0001 << exp_ch);
            HLDA = 1'b0;
            step_chk($sformatf("rot_req%0d", i), 1'b1, 4'b1111, 1'b0, (i == 0) ? 2'd0 : 2'((i - 1) % 4));
            HLDA = 1'b1;
            step_chk($sformatf("rot_grant%0d", i), 1'b1, exp_dack, 1'b1, 2'(exp_ch));
            transferDone = 1'b1;
            step_chk($sformatf("rot_done%0d", i), 1'b0, 4'b1111, 1'b0, 2'(exp_ch));
            chk_ptr($sformatf("rot_ptr%0d", i), 2'(exp_ch));
            transferDone = 1'b0; HLDA = 1'b0;
            step_chk($sformatf("rot_idle%0d", i), 1'b0, 4'b1111, 1'b0, 2'(exp_ch));
        end

        // HLDA drops mid-grant together with transferDone: abort, ptr stays at 0.
        step_chk("abort_req", 1'b1, 4'b1111, 1'b0, 2'd0);
        HLDA = 1'b1;
        step_chk("abort_grant", 1'b1, 4'b1101, 1'b1, 2'd1);
        HLDA = 1'b0; transferDone = 1'b1;
        step_chk("abort", 1'b0, 4'b1111, 1'b0, 2'd1);
        chk_ptr("abort_ptr", 2'd0);
        transferDone = 1'b0;
        step_chk("abort_rereq", 1'b1, 4'b1111, 1'b0, 2'd1);
        HLDA = 1'b1;
        step_chk("abort_regrant", 1'b1, 4'b1101, 1'b1, 2'd1);

        // Reset while ch2 is granted.
        HLDA = 1'b0;
        step_chk("rst_prep_abort", 1'b0, 4'b1111, 1'b0, 2'd1);
        rotatingPriority = 1'b0; DREQ = 4'b0100;
        step_chk("rst_prep_req", 1'b1, 4'b1111, 1'b0, 2'd1);
        HLDA = 1'b1;
        step_chk("rst_prep_grant", 1'b1, 4'b1011, 1'b1, 2'd2);
        RESET = 1'b1;
        step_chk("rst_mid_grant", 1'b0, 4'b1111, 1'b0, 2'd0);
        chk_ptr("rst_mid_grant_ptr", 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
